// File: rtl/ch_acc_pkg.sv
// Shared widths, FSM encoding and the overflow-aware adder used by the
// per-channel accumulators.
package ch_acc_pkg;
  localparam int DEF_NCH   = 3;
  localparam int DEF_IN_W  = 8;
  localparam int DEF_ACC_W = 22;
  localparam int DEF_CNT_W = 16;
  localparam int SUM_MAX   = 64;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Returns {ovf, sum}; only the low w bits of sum are meaningful.
  function automatic logic [SUM_MAX:0] sat_add(input logic [SUM_MAX-1:0] a,
                                               input logic [SUM_MAX-1:0] b,
                                               input int unsigned w,
                                               input logic sat_mode);
    logic [SUM_MAX:0] s;
    logic [SUM_MAX:0] mask;
    logic ovf;
    mask = ((SUM_MAX+1)'(1) << w) - (SUM_MAX+1)'(1);
    s = {1'b0, a} + {1'b0, b};
    ovf = |(s & ~mask);
    if (ovf) s = sat_mode ? mask : (s & mask);
    return {ovf, s[SUM_MAX-1:0]};
  endfunction
endpackage

// File: rtl/ch_acc_lane.sv
// One channel: running sum plus sticky overflow flag. The next-state values
// are exported so the top can snapshot a frame including its final sample.
module ch_acc_lane
  import ch_acc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  add,
  output logic [ACC_W-1:0] acc_nxt,
  output logic             sat_nxt
);
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [SUM_MAX:0] r;
  logic             unused_hi;

  assign r = sat_add(SUM_MAX'(acc), SUM_MAX'(add), ACC_W, SAT);
  assign unused_hi = ^r[SUM_MAX-1:ACC_W];

  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat;
    if (en) begin
      acc_nxt = r[ACC_W-1:0];
      sat_nxt = sat | r[SUM_MAX];
    end
  end

  // Clear wins over add: a sample arriving with clr is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else begin
      acc <= acc_nxt;
      sat <= sat_nxt;
    end
  end
endmodule

// File: rtl/channel_accumulator.sv
// NCH per-channel frame accumulators with a sample counter; each frame end
// snapshots into a valid/ready output bank and restarts the live sums.
module channel_accumulator
  import ch_acc_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SAT   = 1,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic [CH_W-1:0]           in_ch,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NCH-1:0][ACC_W-1:0] out_acc,
  output logic [NCH-1:0]            out_sat,
  output logic [CNT_W-1:0]          out_cnt,
  input  logic [CH_W-1:0]           div_sel,
  output logic [ACC_W-1:0]          divisor
);
  state_t                    state, state_nxt;
  logic                      take, snap, lane_clr;
  logic [NCH-1:0]            lane_en, sat_nxt;
  logic [NCH-1:0][ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;

  // Only a frame-closing sample can be stalled, and only by an unread bank.
  assign in_ready = !in_last || !out_valid || out_ready;
  assign take     = in_valid && in_ready;
  assign snap     = take && in_last;
  assign lane_clr = clr || snap;

  always_comb begin
    for (int i = 0; i < NCH; i++) lane_en[i] = take && (in_ch == CH_W'(i));
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    ch_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .SAT(SAT != 0)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (lane_clr),
      .en      (lane_en[g]),
      .add     (in_data),
      .acc_nxt (acc_nxt[g]),
      .sat_nxt (sat_nxt[g])
    );
  end

  assign cnt_nxt = (take && cnt != '1) ? cnt + CNT_W'(1) : cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (lane_clr) cnt <= '0;
    else               cnt <= cnt_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_acc <= '0;
      out_sat <= '0;
      out_cnt <= '0;
    end else if (snap) begin
      out_acc <= acc_nxt;
      out_sat <= sat_nxt;
      out_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (snap) state_nxt = HOLD;
      HOLD:  if (!snap && out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    out_valid = (state == HOLD);
  end

  always_comb begin
    divisor = '0;
    for (int i = 0; i < NCH; i++)
      if (out_valid && div_sel == CH_W'(i)) divisor = out_acc[i];
  end
endmodule

// File: doc/channel_accumulator.md
Name: channel_accumulator

Overview:
- Parametrised successor to the RGB strength accumulator: NCH independent per-channel running sums of IN_W-bit samples, with saturate or wrap overflow, plus a per-frame sample counter.
- At frame end it snapshots all sums into an output bank behind a valid/ready handshake, then clears the live accumulators for the next frame.
- Sits between the pixel-stream front end and the divider/compare stage, which consumes the snapshot and selects one channel as divisor.

Parameters:
- NCH, 3, number of channels (>=1).
- IN_W, 8, sample width.
- ACC_W, 22, accumulator width (> IN_W).
- CNT_W, 16, sample-counter width.
- SAT, 1, 1 = saturate at all-ones, 0 = wrap modulo 2^ACC_W.
- CH_W, $clog2(NCH) (min 1), channel-index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of live accumulators, counter and sat flags; output bank untouched.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts sample this cycle.
- in_data  in  IN_W  sample value, unsigned.
- in_ch  in  CH_W  target channel index.
- in_last  in  1  sample is last of frame.
- out_valid  out  1  snapshot bank valid.
- out_ready  in  1  consumer takes snapshot.
- out_acc  out  NCH*ACC_W  snapshot sums, channel 0 in LSBs.
- out_sat  out  NCH  per-channel overflow flag of snapshot frame.
- out_cnt  out  CNT_W  samples accepted in snapshot frame, including the last.
- div_sel  in  CH_W  channel to present as divisor.
- divisor  out  ACC_W  out_acc slice for div_sel; 0 when out_valid=0 or div_sel>=NCH.

Behaviour:
- Reset (rst=0, async): all live sums, sat flags, counter, output bank, out_sat, out_cnt = 0; out_valid = 0; FSM = ACCUM.
- Accept: acc = in_valid & in_ready.
  - On acc: live[in_ch] <= live[in_ch] + zero-extended in_data.
  - Live count <= count + 1, saturating at all-ones regardless of SAT.
  - Update visible on the next cycle (1-cycle latency).
- in_ch >= NCH: sample accepted and counted, no sum changes.
- Overflow when the sum carries out of ACC_W:
  - SAT=1: result is all-ones and sat[ch] sets.
  - SAT=0: result is the low ACC_W bits and sat[ch] still sets.
  - sat is sticky until frame end, clr or reset.
- in_ready = !in_last | !out_valid | out_ready. Non-last samples are never stalled; a last sample stalls only while an unconsumed snapshot is held. Combinational from out_valid/out_ready/in_last only, never from in_valid.
- FSM, 2 states:
  - ACCUM -> HOLD on an accepted in_last.
    - Bank <= live sums with that final sample included.
    - out_sat <= flags including that sample.
    - out_cnt <= count+1, saturating.
    - Live sums, flags and count cleared the same edge.
  - HOLD -> ACCUM when out_ready & out_valid and no accepted in_last.
  - HOLD -> HOLD with a new bank when out_ready & out_valid and an accepted in_last in the same cycle. out_valid stays 1.
  - out_valid = (state == HOLD).
- clr has priority over an accepted non-last sample: the sample is dropped and not counted.
- clr with an accepted in_last: the snapshot is still taken from pre-clear live values plus the sample; the live side clears.
- A mid-frame reset discards everything; the frame is not snapshotted.
- Output bank changes only at snapshot; stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package ch_acc_pkg:
  - default widths (IN_W, ACC_W, CNT_W, NCH);
  - FSM state encoding (ACCUM, HOLD);
  - function sat_add(a, b, sat_mode) returning {ovf, sum}.
- One natural sub-module, ch_acc_lane: one channel's ACC_W register plus sticky sat flag, with enable, clear and add inputs.
  - Instantiated NCH times via generate.
  - Replaces the old 22-bit mux/Dff chains.
- Counter, FSM, output bank and divisor mux stay in the top.

Test Plan:
- Basic: defaults; samples (ch0,10),(ch1,20),(ch2,30),(ch0,5,last) -> next cycle out_valid=1, out_acc = {30,20,15}, out_cnt=4, out_sat=0; div_sel=1 gives divisor=20.
- Saturation: SAT=1, ACC_W=10; ch0 receives 255 five times, then last -> out_acc[ch0]=1023, out_sat[0]=1. SAT=0 rerun -> ch0 = 1275 mod 1024 = 251, out_sat[0]=1.
- Backpressure: out_ready=0 and snapshot held; stream 3 non-last samples -> all accepted. A following last sees in_ready=0 until out_ready=1; the same cycle re-snapshots with out_valid held 1 and the new values.
- Clear: mid-frame clr with an accepted non-last sample -> sample dropped. Next frame (ch0,7,last) -> out_acc[ch0]=7, out_cnt=1. Output bank unchanged by clr.
- Reset: assert rst=0 mid-frame while HOLD -> out_valid, out_acc, out_cnt, divisor = 0 immediately (async). After release, first frame accumulates from 0.
- Edge: NCH=3, in_ch=3 sample with last -> counted in out_cnt, all sums unchanged. div_sel=3 -> divisor=0.
